// File: rtl/raster_tri_arbiter_pkg.sv
// Shared raster types: vertices, metadata, triangle bundle.
// Also holds the output-slot state encoding.
package raster_tri_arbiter_pkg;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } coord_3d_t;

  typedef struct packed {
    logic [7:0] tri_id;
    logic [3:0] flags;
  } metadata_t;

  typedef struct packed {
    coord_3d_t v0;
    coord_3d_t v1;
    coord_3d_t v2;
    metadata_t meta;
  } raster_tri_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/raster_tri_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or above
// the pointer, wrapping modulo N. Returns one-hot, index, any.
module raster_tri_arbiter_rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_gnt,
  output logic [IDW-1:0] o_idx,
  output logic           o_any
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [IDW:0]   w_sum;

  // rotate so the pointer sits at bit 0, take lowest set offset
  always_comb begin
    w_dbl = {i_req, i_req};
    w_rot = w_dbl[i_ptr +: N];
    w_sum = '0;
    o_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_any = 1'b1;
        w_sum = {1'b0, i_ptr} + (IDW+1)'(k);
      end
    end
    if (w_sum >= (IDW+1)'(N)) begin
      w_sum = w_sum - (IDW+1)'(N);
    end
    o_idx = w_sum[IDW-1:0];
    o_gnt = o_any ? (N'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/raster_tri_arbiter.sv
// Round-robin arbiter feeding one registered triangle slot.
// Define RASTER_ARB_STATS_EN for per-requester accept counters.
import raster_tri_arbiter_pkg::*;

module raster_tri_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int STAT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_vld,
  input  coord_3d_t [NUM_REQ-1:0] req_v0,
  input  coord_3d_t [NUM_REQ-1:0] req_v1,
  input  coord_3d_t [NUM_REQ-1:0] req_v2,
  input  metadata_t [NUM_REQ-1:0] req_meta,
  output logic [NUM_REQ-1:0]     req_rdy,
  output logic                   tri_vld,
  output coord_3d_t              tri_v0,
  output coord_3d_t              tri_v1,
  output coord_3d_t              tri_v2,
  output metadata_t              tri_meta,
  output logic [ID_W-1:0]        tri_src,
  input  logic                   tri_rdy,
`ifdef RASTER_ARB_STATS_EN
  output logic [NUM_REQ-1:0][STAT_W-1:0] stat_cnt,
`endif
  output logic                   busy
);

  if (NUM_REQ < 1 || STAT_W < 1) begin : g_bad_cfg
    $error("raster_tri_arbiter: NUM_REQ and STAT_W must be >= 1");
  end

  slot_state_e         r_state;
  slot_state_e         w_state_nxt;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     w_ptr_nxt;
  logic [ID_W-1:0]     r_src;
  logic [ID_W-1:0]     w_idx;
  logic [NUM_REQ-1:0]  w_gnt;
  logic                w_any;
  logic                w_can_load;
  logic                w_accept;
  raster_tri_t         r_slot;
  raster_tri_t         w_req_tri;

  raster_tri_arbiter_rr_pick #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_pick (
    .i_req (req_vld),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // mux the winning requester's triangle into one bundle
  always_comb begin
    w_req_tri      = '0;
    w_req_tri.v0   = req_v0[w_idx];
    w_req_tri.v1   = req_v1[w_idx];
    w_req_tri.v2   = req_v2[w_idx];
    w_req_tri.meta = req_meta[w_idx];
  end

  // slot FSM next state, pointer advance and grant
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_can_load  = (r_state == ST_EMPTY) || tri_rdy;
    w_accept    = rst_n && w_can_load && w_any;
    req_rdy     = w_accept ? w_gnt : '0;
    if (w_accept) begin
      w_state_nxt = ST_FULL;
      w_ptr_nxt   = (w_idx == ID_W'(NUM_REQ - 1)) ?
                    '0 : w_idx + 1'b1;
    end else if (r_state == ST_FULL && tri_rdy) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  // state, pointer and output slot registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_ptr   <= '0;
      r_src   <= '0;
      r_slot  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      if (w_accept) begin
        r_slot <= w_req_tri;
        r_src  <= w_idx;
      end
    end
  end

`ifdef RASTER_ARB_STATS_EN
  logic [NUM_REQ-1:0][STAT_W-1:0] r_stat;

  // saturating accept counters, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_accept && w_gnt[i] && (r_stat[i] != '1)) begin
          r_stat[i] <= r_stat[i] + 1'b1;
        end
      end
    end
  end

  assign stat_cnt = r_stat;
`endif

  assign tri_vld  = (r_state == ST_FULL);
  assign tri_v0   = r_slot.v0;
  assign tri_v1   = r_slot.v1;
  assign tri_v2   = r_slot.v2;
  assign tri_meta = r_slot.meta;
  assign tri_src  = r_src;
  assign busy     = (r_state == ST_FULL) || (|req_vld);

endmodule

// File: tb/tb_raster_tri_arbiter.sv
// Directed bench for raster_tri_arbiter with an in-order
// scoreboard of expected triangles.
import raster_tri_arbiter_pkg::*;

module tb_raster_tri_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int STAT_W  = 4;
  localparam int TW      = ID_W + $bits(raster_tri_t);

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_vld;
  coord_3d_t [NUM_REQ-1:0]  req_v0;
  coord_3d_t [NUM_REQ-1:0]  req_v1;
  coord_3d_t [NUM_REQ-1:0]  req_v2;
  metadata_t [NUM_REQ-1:0]  req_meta;
  logic [NUM_REQ-1:0]       req_rdy;
  logic                     tri_vld;
  coord_3d_t                tri_v0;
  coord_3d_t                tri_v1;
  coord_3d_t                tri_v2;
  metadata_t                tri_meta;
  logic [ID_W-1:0]          tri_src;
  logic                     tri_rdy;
  logic                     busy;
`ifdef RASTER_ARB_STATS_EN
  logic [NUM_REQ-1:0][STAT_W-1:0] stat_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int seq[NUM_REQ];
  int rem[NUM_REQ];
  logic [TW-1:0] sb[$];
  logic [TW-1:0] w_obs;
  logic [TW-1:0] hold;

  assign w_obs = {tri_src, tri_v0, tri_v1, tri_v2, tri_meta};

  raster_tri_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .STAT_W  (STAT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_vld  (req_vld),
    .req_v0   (req_v0),
    .req_v1   (req_v1),
    .req_v2   (req_v2),
    .req_meta (req_meta),
    .req_rdy  (req_rdy),
    .tri_vld  (tri_vld),
    .tri_v0   (tri_v0),
    .tri_v1   (tri_v1),
    .tri_v2   (tri_v2),
    .tri_meta (tri_meta),
    .tri_src  (tri_src),
    .tri_rdy  (tri_rdy),
`ifdef RASTER_ARB_STATS_EN
    .stat_cnt (stat_cnt),
`endif
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic raster_tri_t mk(input int i, input int s);
    raster_tri_t t;
    logic [15:0] b;
    b = {i[3:0], s[11:0]};
    t.v0 = '{x: b, y: ~b, z: b ^ 16'h5a5a};
    t.v1 = '{x: b + 16'd1, y: b + 16'd2, z: b + 16'd3};
    t.v2 = '{x: b ^ 16'h0f0f, y: b + 16'h100, z: ~b ^ 16'h1};
    t.meta = '{tri_id: s[7:0], flags: i[3:0]};
    return t;
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs,
                     input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i);
    raster_tri_t t;
    t = mk(i, seq[i]);
    req_v0[i]   = t.v0;
    req_v1[i]   = t.v1;
    req_v2[i]   = t.v2;
    req_meta[i] = t.meta;
  endtask

  // one cycle: check grant/vld/busy, push expected, advance requesters
  task automatic step(input logic [3:0] exp_rdy, input logic exp_vld,
                      input string tag);
    logic [3:0] act;
    @(negedge clk);
    act = req_rdy;
    chk({tag, ".rdy"}, 160'(act), 160'(exp_rdy));
    chk({tag, ".vld"}, 160'(tri_vld), 160'(exp_vld));
    chk({tag, ".busy"}, 160'(busy), 160'(exp_vld | (|req_vld)));
    for (int i = 0; i < NUM_REQ; i++) begin
      if (exp_rdy[i]) sb.push_back({ID_W'(i), mk(i, seq[i])});
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (act[i] && req_vld[i]) begin
        seq[i]++;
        rem[i]--;
        if (rem[i] <= 0) req_vld[i] = 1'b0;
        drive(i);
      end
    end
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    req_vld = '1;
    for (int i = 0; i < NUM_REQ; i++) drive(i);
    @(negedge clk);
    chk({tag, ".rdy_rst"}, 160'(req_rdy), 160'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({tag, ".rdy_rst2"}, 160'(req_rdy), 160'(0));
    chk({tag, ".vld_rst"}, 160'(tri_vld), 160'(0));
    chk({tag, ".src_rst"}, 160'(tri_src), 160'(0));
    chk({tag, ".v0_rst"}, 160'(tri_v0), 160'(0));
    chk({tag, ".meta_rst"}, 160'(tri_meta), 160'(0));
    chk({tag, ".busy_rst"}, 160'(busy), 160'(1));
`ifdef RASTER_ARB_STATS_EN
    chk({tag, ".stat_rst"}, 160'(stat_cnt), 160'(0));
`endif
    @(posedge clk);
    #1;
    req_vld = '0;
    rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < NUM_REQ; i++) rem[i] = 0;
  endtask

  // scoreboard: each triangle leaving the slot must match in order
  always @(negedge clk) begin
    if (rst_n === 1'b1 && tri_vld === 1'b1 && tri_rdy === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 160'(sb.size()), 160'(1));
      end else begin
        chk("sb_out", 160'(w_obs), 160'(sb.pop_front()));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    tri_rdy = 1'b1;
    req_vld = '0;
    req_v0 = '0;
    req_v1 = '0;
    req_v2 = '0;
    req_meta = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      seq[i] = 1;
      rem[i] = 0;
    end
    @(posedge clk);
    #1;
    do_reset("r0");

    // single requester 2, three back-to-back triangles
    rem[2] = 3;
    req_vld[2] = 1'b1;
    step(4'b0100, 1'b0, "t1a");
    step(4'b0100, 1'b1, "t1b");
    step(4'b0100, 1'b1, "t1c");
    step(4'b0000, 1'b1, "t1d");
    step(4'b0000, 1'b0, "t1e");

    // all requesters held high from reset
    do_reset("r1");
    for (int i = 0; i < NUM_REQ; i++) begin
      rem[i] = 100;
      drive(i);
    end
    req_vld = '1;
    step(4'b0001, 1'b0, "t2_0");
    step(4'b0010, 1'b1, "t2_1");
    step(4'b0100, 1'b1, "t2_2");
    step(4'b1000, 1'b1, "t2_3");
    step(4'b0001, 1'b1, "t2_4");
    step(4'b0010, 1'b1, "t2_5");
    req_vld = '0;
    for (int i = 0; i < NUM_REQ; i++) rem[i] = 0;
    step(4'b0000, 1'b1, "t2_d0");
    step(4'b0000, 1'b0, "t2_d1");

    // backpressure: slot from req 1, pointer now 2
    rem[1] = 1;
    req_vld[1] = 1'b1;
    hold = {ID_W'(1), mk(1, seq[1])};
    step(4'b0010, 1'b0, "t3load");
    tri_rdy = 1'b0;
    rem[0] = 1;
    rem[3] = 1;
    req_vld[0] = 1'b1;
    req_vld[3] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(4'b0000, 1'b1, "t3stall");
      chk("t3hold", 160'(w_obs), 160'(hold));
    end
    tri_rdy = 1'b1;
    step(4'b1000, 1'b1, "t3g3");
    step(4'b0001, 1'b1, "t3g0");
    step(4'b0000, 1'b1, "t3d0");
    step(4'b0000, 1'b0, "t3d1");

    // drain, then lone req 0 again with pointer at 1
    rem[0] = 1;
    req_vld[0] = 1'b1;
    step(4'b0001, 1'b0, "t4a");
    step(4'b0000, 1'b1, "t4b");
    step(4'b0000, 1'b0, "t4c");
    rem[0] = 1;
    req_vld[0] = 1'b1;
    step(4'b0001, 1'b0, "t4d");
    step(4'b0000, 1'b1, "t4e");
    step(4'b0000, 1'b0, "t4f");

    // reset while full and stalled
    rem[2] = 1;
    req_vld[2] = 1'b1;
    step(4'b0100, 1'b0, "t5load");
    tri_rdy = 1'b0;
    step(4'b0000, 1'b1, "t5stall");
    rst_n = 1'b0;
    rem[1] = 1;
    rem[3] = 1;
    req_vld[1] = 1'b1;
    req_vld[3] = 1'b1;
    @(negedge clk);
    chk("t5rdy_rst", 160'(req_rdy), 160'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tri_rdy = 1'b1;
    sb.delete();
    chk("t5vld", 160'(tri_vld), 160'(0));
    chk("t5src", 160'(tri_src), 160'(0));
    chk("t5v0", 160'(tri_v0), 160'(0));
    step(4'b0010, 1'b0, "t5g1");
    step(4'b1000, 1'b1, "t5g3");
    step(4'b0000, 1'b1, "t5d0");
    step(4'b0000, 1'b0, "t5d1");

`ifdef RASTER_ARB_STATS_EN
    // saturation of the 4-bit counter for requester 0
    do_reset("r2");
    rem[0] = 20;
    drive(0);
    req_vld[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(4'b0001, (k > 0), "t6");
    end
    step(4'b0000, 1'b1, "t6d0");
    step(4'b0000, 1'b0, "t6d1");
    chk("t6stat0", 160'(stat_cnt[0]), 160'(15));
    chk("t6stat1", 160'(stat_cnt[1]), 160'(0));
    chk("t6stat2", 160'(stat_cnt[2]), 160'(0));
    chk("t6stat3", 160'(stat_cnt[3]), 160'(0));
`endif

    chk("sb_drained", 160'(sb.size()), 160'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
